// File: rtl/lc3_pkg.sv
// Shared definitions for the LC-3 memory responder.
//   KBSR_ADDR..DDR_ADDR : memory-mapped keyboard / display device addresses
//   state_e             : responder FSM state encoding
package lc3_pkg;

  localparam logic [15:0] KBSR_ADDR = 16'hFE00;
  localparam logic [15:0] KBDR_ADDR = 16'hFE02;
  localparam logic [15:0] DSR_ADDR  = 16'hFE04;
  localparam logic [15:0] DDR_ADDR  = 16'hFE06;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/lc3_mem_array.sv
// Synchronous single-port RAM, 2^MEM_AW x 16, read-first, registered output.
//   CLK  : clock
//   WE   : write enable for ADDR/DIN on this edge
//   ADDR : word address
//   DIN  : write data
//   DOUT : word at ADDR as of the previous edge (old data on a write edge)
// Contents are never reset.
module lc3_mem_array #(
  parameter int MEM_AW = 10
) (
  input  logic              CLK,
  input  logic              WE,
  input  logic [MEM_AW-1:0] ADDR,
  input  logic [15:0]       DIN,
  output logic [15:0]       DOUT
);

  logic [15:0] mem [2**MEM_AW];
  logic [15:0] dout_q;

  always_ff @(posedge CLK) begin
    if (WE) mem[ADDR] <= DIN;
    dout_q <= mem[ADDR];
  end

  assign DOUT = dout_q;

endmodule

// File: rtl/lc3_mem_responder.sv
// LC-3 memory-side responder: RAM plus keyboard/display device registers.
//   CLK, RESET_N          : clock, async active-low reset
//   MIO_EN, R_W, MAR,
//   MDR_IN                : request, direction (1 = write), address, write data
//   MEM_DATA, R           : read data, one-cycle ready pulse per access
//   KB_STROBE, KB_CHAR    : keyboard character strobe and value
//   DISP_VALID, DISP_CHAR,
//   DISP_READY            : display character handshake
//
// state   | meaning
// IDLE    | waiting for MIO_EN; request captured on the edge it is seen
// BUSY    | counting wait states; access performed on the edge counter = 0
// DONE    | R high, MEM_DATA holds the result; back to IDLE next edge
module lc3_mem_responder
  import lc3_pkg::*;
#(
  parameter int MEM_AW      = 10,
  parameter int WAIT_CYCLES = 3
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        MIO_EN,
  input  logic        R_W,
  input  logic [15:0] MAR,
  input  logic [15:0] MDR_IN,
  output logic [15:0] MEM_DATA,
  output logic        R,
  input  logic        KB_STROBE,
  input  logic [7:0]  KB_CHAR,
  output logic        DISP_VALID,
  output logic [7:0]  DISP_CHAR,
  input  logic        DISP_READY
);

  localparam int CW = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(WAIT_CYCLES);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rw_q, rw_d;
  logic [15:0]   mar_q, mar_d;
  logic [15:0]   mdr_q, mdr_d;
  logic          sel_ram_q, sel_ram_d;
  logic [15:0]   dev_data_q, dev_data_d;
  logic          kb_full_q, kb_full_d;
  logic [7:0]    kbdr_q, kbdr_d;
  logic          disp_valid_q, disp_valid_d;
  logic [7:0]    disp_char_q, disp_char_d;

  logic          access;
  logic          in_ram;
  logic          is_dev;
  logic          kbdr_rd;
  logic          ddr_wr;
  logic          ram_we;
  logic [15:0]   ram_dout;

  assign access  = (state_q == ST_BUSY) && (cnt_q == '0);
  assign in_ram  = (mar_q >> MEM_AW) == 16'd0;
  assign is_dev  = (mar_q == KBSR_ADDR) || (mar_q == KBDR_ADDR) ||
                   (mar_q == DSR_ADDR)  || (mar_q == DDR_ADDR);
  assign kbdr_rd = access && !rw_q && (mar_q == KBDR_ADDR);
  assign ddr_wr  = access && rw_q && (mar_q == DDR_ADDR) && !disp_valid_q;
  assign ram_we  = access && rw_q && in_ram && !is_dev;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rw_d         = rw_q;
    mar_d        = mar_q;
    mdr_d        = mdr_q;
    sel_ram_d    = sel_ram_q;
    dev_data_d   = dev_data_q;
    kb_full_d    = kb_full_q;
    kbdr_d       = kbdr_q;
    disp_valid_d = disp_valid_q;
    disp_char_d  = disp_char_q;

    case (state_q)
      ST_IDLE: begin
        if (MIO_EN) begin
          rw_d    = R_W;
          mar_d   = MAR;
          mdr_d   = MDR_IN;
          cnt_d   = CNT_LOAD;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          state_d = ST_DONE;
          // RAM reads come straight from the array's output register;
          // everything else (device reads, all writes) goes through dev_data.
          sel_ram_d  = !rw_q && in_ram && !is_dev;
          dev_data_d = '0;
          if (!rw_q) begin
            case (mar_q)
              KBSR_ADDR: dev_data_d = {kb_full_q, 15'b0};
              KBDR_ADDR: dev_data_d = {8'b0, kbdr_q};
              DSR_ADDR:  dev_data_d = {!disp_valid_q, 15'b0};
              default:   dev_data_d = '0;
            endcase
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // A strobe landing on a KBDR read edge still loads: the reader gets the
    // old character and the new one stays pending.
    if (KB_STROBE && (!kb_full_q || kbdr_rd)) begin
      kbdr_d    = KB_CHAR;
      kb_full_d = 1'b1;
    end else if (kbdr_rd) begin
      kb_full_d = 1'b0;
    end

    // Transfer and DDR write are mutually exclusive: a write only lands
    // while DISP_VALID is low, a transfer only happens while it is high.
    if (disp_valid_q && DISP_READY) begin
      disp_valid_d = 1'b0;
    end else if (ddr_wr) begin
      disp_valid_d = 1'b1;
      disp_char_d  = mdr_q[7:0];
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      rw_q         <= 1'b0;
      mar_q        <= '0;
      mdr_q        <= '0;
      sel_ram_q    <= 1'b0;
      dev_data_q   <= '0;
      kb_full_q    <= 1'b0;
      kbdr_q       <= '0;
      disp_valid_q <= 1'b0;
      disp_char_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rw_q         <= rw_d;
      mar_q        <= mar_d;
      mdr_q        <= mdr_d;
      sel_ram_q    <= sel_ram_d;
      dev_data_q   <= dev_data_d;
      kb_full_q    <= kb_full_d;
      kbdr_q       <= kbdr_d;
      disp_valid_q <= disp_valid_d;
      disp_char_q  <= disp_char_d;
    end
  end

  lc3_mem_array #(.MEM_AW(MEM_AW)) u_ram (
    .CLK  (CLK),
    .WE   (ram_we),
    .ADDR (mar_q[MEM_AW-1:0]),
    .DIN  (mdr_q),
    .DOUT (ram_dout)
  );

  assign R          = (state_q == ST_DONE);
  assign MEM_DATA   = sel_ram_q ? ram_dout : dev_data_q;
  assign DISP_VALID = disp_valid_q;
  assign DISP_CHAR  = disp_char_q;

endmodule

// File: tb/tb_lc3_mem_responder.sv
module tb_lc3_mem_responder;

  localparam int WAIT_MAIN = 3;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        RESET_N, MIO_EN, R_W, KB_STROBE, DISP_READY;
  logic [15:0] MAR, MDR_IN, MEM_DATA;
  logic        R, DISP_VALID;
  logic [7:0]  KB_CHAR, DISP_CHAR;

  logic        MIO_EN_z, R_W_z, R_z, DISP_VALID_z;
  logic [15:0] MAR_z, MDR_IN_z, MEM_DATA_z;
  logic [7:0]  DISP_CHAR_z;
  logic        KB_STROBE_z = 1'b0;
  logic        DISP_READY_z = 1'b0;
  logic [7:0]  KB_CHAR_z = 8'h00;

  lc3_mem_responder #(.MEM_AW(10), .WAIT_CYCLES(WAIT_MAIN)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .MIO_EN(MIO_EN), .R_W(R_W), .MAR(MAR),
    .MDR_IN(MDR_IN), .MEM_DATA(MEM_DATA), .R(R), .KB_STROBE(KB_STROBE),
    .KB_CHAR(KB_CHAR), .DISP_VALID(DISP_VALID), .DISP_CHAR(DISP_CHAR),
    .DISP_READY(DISP_READY)
  );

  lc3_mem_responder #(.MEM_AW(10), .WAIT_CYCLES(0)) dut0 (
    .CLK(CLK), .RESET_N(RESET_N), .MIO_EN(MIO_EN_z), .R_W(R_W_z), .MAR(MAR_z),
    .MDR_IN(MDR_IN_z), .MEM_DATA(MEM_DATA_z), .R(R_z), .KB_STROBE(KB_STROBE_z),
    .KB_CHAR(KB_CHAR_z), .DISP_VALID(DISP_VALID_z), .DISP_CHAR(DISP_CHAR_z),
    .DISP_READY(DISP_READY_z)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: plain memory map behaviour of the responder
  logic [15:0] ram_m [int];
  bit          kb_full_m;
  logic [7:0]  kbdr_m;
  bit          dv_m;
  logic [7:0]  dc_m;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    kb_full_m = 1'b0; kbdr_m = 8'h00; dv_m = 1'b0; dc_m = 8'h00;
  endtask

  task automatic model_access(input bit w, input logic [15:0] addr, input logic [15:0] data,
                              input bit coll, input logic [7:0] cc,
                              output logic [15:0] exp, output bit known);
    exp = 16'h0000;
    known = 1'b1;
    if (!w) begin
      case (addr)
        16'hFE00: exp = {kb_full_m, 15'b0};
        16'hFE02: begin
          exp = {8'h00, kbdr_m};
          if (coll) begin kbdr_m = cc; kb_full_m = 1'b1; end
          else kb_full_m = 1'b0;
        end
        16'hFE04: exp = {~dv_m, 15'b0};
        16'hFE06: exp = 16'h0000;
        default: begin
          if (addr < 16'd1024) begin
            known = ram_m.exists(int'(addr));
            if (known) exp = ram_m[int'(addr)];
          end
        end
      endcase
    end else begin
      if (addr == 16'hFE06) begin
        if (!dv_m) begin dv_m = 1'b1; dc_m = data[7:0]; end
      end else if (addr < 16'd1024) begin
        ram_m[int'(addr)] = data;
      end
    end
  endtask

  // Drives one request; returns edges from capture to R and the read data.
  task automatic do_access(input bit z, input bit w, input logic [15:0] addr,
                           input logic [15:0] data, input bit coll, input logic [7:0] cc,
                           output logic [15:0] rd, output int lat);
    if (!z) begin MIO_EN = 1'b1; R_W = w; MAR = addr; MDR_IN = data; end
    else begin MIO_EN_z = 1'b1; R_W_z = w; MAR_z = addr; MDR_IN_z = data; end
    @(posedge CLK); #1;
    MIO_EN = 1'b0; MIO_EN_z = 1'b0;
    lat = 0;
    rd = 16'h0000;
    for (int n = 1; n <= 20; n++) begin
      if (coll && n == WAIT_MAIN + 1) begin KB_STROBE = 1'b1; KB_CHAR = cc; end
      @(posedge CLK); #1;
      KB_STROBE = 1'b0;
      if ((z ? R_z : R) === 1'b1) begin
        lat = n;
        rd = z ? MEM_DATA_z : MEM_DATA;
        break;
      end
    end
    @(posedge CLK); #1;
    chk("r_one_cycle", {15'b0, (z ? R_z : R)}, 16'h0000);
  endtask

  task automatic acc(input string tag, input bit w, input logic [15:0] addr,
                     input logic [15:0] data, input bit coll, input logic [7:0] cc);
    logic [15:0] exp, rd;
    bit known;
    int lat;
    model_access(w, addr, data, coll, cc, exp, known);
    do_access(1'b0, w, addr, data, coll, cc, rd, lat);
    chk({tag, "_lat"}, 16'(lat), 16'(WAIT_MAIN + 1));
    if (known) chk({tag, "_data"}, rd, exp);
    chk({tag, "_dv"}, {15'b0, DISP_VALID}, {15'b0, dv_m});
    chk({tag, "_dc"}, {8'h00, DISP_CHAR}, {8'h00, dc_m});
  endtask

  task automatic strobe(input logic [7:0] c);
    KB_STROBE = 1'b1; KB_CHAR = c;
    @(posedge CLK); #1;
    KB_STROBE = 1'b0;
    if (!kb_full_m) begin kbdr_m = c; kb_full_m = 1'b1; end
  endtask

  task automatic xfer();
    DISP_READY = 1'b1;
    @(posedge CLK); #1;
    DISP_READY = 1'b0;
    dv_m = 1'b0;
    chk("xfer_dv", {15'b0, DISP_VALID}, 16'h0000);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] rd;
    int lat;
    int seen;
    logic [15:0] pool [8];
    logic [15:0] devs [4];

    RESET_N = 1'b0; MIO_EN = 1'b0; R_W = 1'b0; MAR = '0; MDR_IN = '0;
    KB_STROBE = 1'b0; KB_CHAR = '0; DISP_READY = 1'b0;
    MIO_EN_z = 1'b0; R_W_z = 1'b0; MAR_z = '0; MDR_IN_z = '0;
    model_reset();
    #23;
    chk("rst_r", {15'b0, R}, 16'h0000);
    chk("rst_mem_data", MEM_DATA, 16'h0000);
    chk("rst_dv", {15'b0, DISP_VALID}, 16'h0000);
    chk("rst_dc", {8'h00, DISP_CHAR}, 16'h0000);
    chk("rst_r0", {15'b0, R_z}, 16'h0000);
    @(negedge CLK); RESET_N = 1'b1;
    @(posedge CLK); #1;

    // RAM write then read
    acc("wr5", 1'b1, 16'h0005, 16'h1234, 1'b0, 8'h00);
    acc("rd5", 1'b0, 16'h0005, 16'h0000, 1'b0, 8'h00);

    // Zero-wait instance, back-to-back requests
    do_access(1'b1, 1'b1, 16'h0003, 16'h00AA, 1'b0, 8'h00, rd, lat);
    chk("z_wr3_lat", 16'(lat), 16'd1);
    do_access(1'b1, 1'b1, 16'h0004, 16'h0055, 1'b0, 8'h00, rd, lat);
    chk("z_wr4_lat", 16'(lat), 16'd1);
    do_access(1'b1, 1'b0, 16'h0003, 16'h0000, 1'b0, 8'h00, rd, lat);
    chk("z_rd3_lat", 16'(lat), 16'd1);
    chk("z_rd3_data", rd, 16'h00AA);
    do_access(1'b1, 1'b0, 16'h0004, 16'h0000, 1'b0, 8'h00, rd, lat);
    chk("z_rd4_lat", 16'(lat), 16'd1);
    chk("z_rd4_data", rd, 16'h0055);

    // Keyboard
    strobe(8'h41);
    acc("kbsr_full", 1'b0, 16'hFE00, 16'h0000, 1'b0, 8'h00);
    acc("kbdr_a", 1'b0, 16'hFE02, 16'h0000, 1'b0, 8'h00);
    acc("kbsr_empty", 1'b0, 16'hFE00, 16'h0000, 1'b0, 8'h00);
    strobe(8'h42);
    strobe(8'h43);
    acc("kbdr_drop", 1'b0, 16'hFE02, 16'h0000, 1'b0, 8'h00);

    // Keyboard collision on the KBDR read edge
    strobe(8'h44);
    acc("kbdr_coll", 1'b0, 16'hFE02, 16'h0000, 1'b1, 8'h45);
    acc("kbsr_coll", 1'b0, 16'hFE00, 16'h0000, 1'b0, 8'h00);
    acc("kbdr_new", 1'b0, 16'hFE02, 16'h0000, 1'b0, 8'h00);
    acc("kbsr_after", 1'b0, 16'hFE00, 16'h0000, 1'b0, 8'h00);

    // Display
    acc("ddr_wr", 1'b1, 16'hFE06, 16'h0048, 1'b0, 8'h00);
    acc("dsr_busy", 1'b0, 16'hFE04, 16'h0000, 1'b0, 8'h00);
    acc("ddr_drop", 1'b1, 16'hFE06, 16'h0049, 1'b0, 8'h00);
    xfer();
    acc("dsr_ready", 1'b0, 16'hFE04, 16'h0000, 1'b0, 8'h00);
    acc("ddr_rd", 1'b0, 16'hFE06, 16'h0000, 1'b0, 8'h00);

    // Out-of-range addresses alias nothing
    acc("wr0", 1'b1, 16'h0000, 16'h1111, 1'b0, 8'h00);
    acc("rd8000", 1'b0, 16'h8000, 16'h0000, 1'b0, 8'h00);
    acc("wr8000", 1'b1, 16'h8000, 16'hBEEF, 1'b0, 8'h00);
    acc("rd0", 1'b0, 16'h0000, 16'h0000, 1'b0, 8'h00);

    // Reset in the middle of a write
    acc("pre10", 1'b1, 16'h0010, 16'h5A5A, 1'b0, 8'h00);
    strobe(8'h5A);
    acc("ddr_pre", 1'b1, 16'hFE06, 16'h0061, 1'b0, 8'h00);
    MIO_EN = 1'b1; R_W = 1'b1; MAR = 16'h0010; MDR_IN = 16'hDEAD;
    @(posedge CLK); #1;
    MIO_EN = 1'b0;
    @(posedge CLK); #1;
    RESET_N = 1'b0;
    #2;
    chk("abort_rst_r", {15'b0, R}, 16'h0000);
    chk("abort_rst_dv", {15'b0, DISP_VALID}, 16'h0000);
    chk("abort_rst_dc", {8'h00, DISP_CHAR}, 16'h0000);
    #3;
    RESET_N = 1'b1;
    model_reset();
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge CLK); #1;
      if (R === 1'b1) seen++;
    end
    chk("abort_no_r", 16'(seen), 16'h0000);
    acc("rd10", 1'b0, 16'h0010, 16'h0000, 1'b0, 8'h00);
    acc("kbsr_rst", 1'b0, 16'hFE00, 16'h0000, 1'b0, 8'h00);

    // Randomized mix against the model
    for (int i = 0; i < 8; i++) pool[i] = 16'($urandom_range(32, 1023));
    devs[0] = 16'hFE00; devs[1] = 16'hFE02; devs[2] = 16'hFE04; devs[3] = 16'hFE06;
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 7))
        0, 1: acc("rnd_wr", 1'b1, pool[$urandom_range(0, 7)], 16'($urandom), 1'b0, 8'h00);
        2, 3: acc("rnd_rd", 1'b0, pool[$urandom_range(0, 7)], 16'h0000, 1'b0, 8'h00);
        4:    acc("rnd_oor", 1'($urandom_range(0, 1)), 16'($urandom_range(16'h0400, 16'hF3FF)),
                  16'($urandom), 1'b0, 8'h00);
        5:    strobe(8'($urandom));
        6:    acc("rnd_dev", 1'($urandom_range(0, 1)), devs[$urandom_range(0, 3)],
                  16'($urandom), 1'b0, 8'h00);
        default: begin
          if ($urandom_range(0, 1) == 0) xfer();
          else acc("rnd_ddr", 1'b1, 16'hFE06, 16'($urandom), 1'b0, 8'h00);
        end
      endcase
    end

    chk("z_dv_idle", {15'b0, DISP_VALID_z}, 16'h0000);
    chk("z_dc_idle", {8'h00, DISP_CHAR_z}, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
